// File: rtl/routed_fifos.sv
// routed_fifos: one write stream demultiplexed by a destination tag into
// NUM_REQS independent first-word-fall-through FIFOs, each drained by its
// own consumer.
// Optional feature: define ROUTED_FIFOS_DROPCNT_EN to add the saturating
// drop_cnt output that counts rejected pushes.

`ifndef NUM_REQS
`define NUM_REQS 4
`endif
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 4
`endif

module routed_fifos #(
  parameter int NUM_REQS = `NUM_REQS,
  parameter int WIDTH    = `FIFO_DWIDTH,
  parameter int DEPTH    = `FIFO_DEPTH,
  parameter int DWID     = $clog2(NUM_REQS),
  parameter int CWID     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DWID-1:0]           dest,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      in_rdy,
  input  logic [NUM_REQS-1:0]       pop,
  output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
  output logic [NUM_REQS-1:0]       empty,
  output logic [NUM_REQS-1:0]       full
`ifdef ROUTED_FIFOS_DROPCNT_EN
  ,
  output logic [CWID-1:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0]    mem  [NUM_REQS][DEPTH];
  logic [PW-1:0]       wptr [NUM_REQS];
  logic [PW-1:0]       rptr [NUM_REQS];
  logic [NUM_REQS-1:0] wr_en;
  logic [NUM_REQS-1:0] rd_en;

  // Status flags and fall-through head words straight from the registered pointers.
  always_comb begin
    empty         = '0;
    full          = '0;
    flat_data_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][AW-1:0] == rptr[i][AW-1:0]) && (wptr[i][AW] != rptr[i][AW]);
      flat_data_out[i*WIDTH +: WIDTH] = mem[i][rptr[i][AW-1:0]];
    end
  end

  // Route decode: an out-of-range tag matches no FIFO, so in_rdy stays low.
  always_comb begin
    in_rdy = 1'b0;
    wr_en  = '0;
    rd_en  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (dest == DWID'(i)) in_rdy = !full[i];
      rd_en[i] = pop[i] && !empty[i];
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      wr_en[i] = push && in_rdy && (dest == DWID'(i));
    end
  end

  // Storage write; contents are intentionally not reset, and a reset cycle stores nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!rst && wr_en[i]) mem[i][wptr[i][AW-1:0]] <= data_in;
    end
  end

  // Pointer update; full/empty come from start-of-cycle state, so same-cycle
  // push+pop on a full FIFO only pops and on an empty FIFO only pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (wr_en[i]) wptr[i] <= wptr[i] + PW'(1);
        if (rd_en[i]) rptr[i] <= rptr[i] + PW'(1);
      end
    end
  end

`ifdef ROUTED_FIFOS_DROPCNT_EN
  // Saturating count of pushes rejected for a full or nonexistent destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (push && !in_rdy && (drop_cnt != {CWID{1'b1}})) begin
      drop_cnt <= drop_cnt + CWID'(1);
    end
  end
`else
  // CWID only sizes drop_cnt; without the counter it has no load.
  logic unused_cwid;
  assign unused_cwid = (CWID > 0);
`endif

endmodule
